// File: rtl/dsm_pkg.sv
// Shared constants for the third-order CIC sigma-delta decimator.
// No ports. Supplies the CIC order, output width, the number of start-up
// results that are discarded, the default decimation exponent and the
// helper that sizes the internal datapath from that exponent.
package dsm_pkg;

  localparam int CIC_ORDER     = 3;
  localparam int OUT_W         = 16;
  localparam int SETTLE_CNT    = 3;
  localparam int LOG2R_DEFAULT = 6;

  // A full-scale bitstream through an N-th order CIC grows by R^N, so
  // N*log2(R) bits plus one more to hold the exact full-scale value R^N.
  function automatic int cic_width(input int log2r);
    return CIC_ORDER * log2r + 1;
  endfunction

endpackage

// File: rtl/dsm_decim3_if.sv
// Bitstream-in / sample-out bundle of the CIC decimator.
// Signals:
//   in_en     - qualifies in_bit for one clock
//   in_bit    - modulator bitstream (1 = full scale, 0 = zero)
//   out_data  - unsigned decimated sample, held between strobes
//   out_valid - one-cycle strobe marking a new out_data
//   settled   - high once the start-up transient has been flushed
// master drives the bitstream, slave (the decimator) drives the results.
interface dsm_decim3_if;
  import dsm_pkg::*;

  logic             in_en;
  logic             in_bit;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             settled;

  modport master (
    output in_en,
    output in_bit,
    input  out_data,
    input  out_valid,
    input  settled
  );

  modport slave (
    input  in_en,
    input  in_bit,
    output out_data,
    output out_valid,
    output settled
  );

endinterface

// File: rtl/cic_integ.sv
// Enabled modular accumulator used as one CIC integrator stage.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears the accumulator
//   en_i   - accumulate din_i this cycle, hold otherwise
//   din_i  - DATA_W-bit addend
//   acc_o  - current (pre-update) accumulator value
// The sum wraps modulo 2^DATA_W; a CIC relies on that wrap being exact.
module cic_integ #(
  parameter int DATA_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  assign acc_d = acc_q + din_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dsm_decim3.sv
// Third-order CIC decimator for a 1-bit sigma-delta stream, R = 2^LOG2R.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset of all state
//   bus   - dsm_decim3_if slave: in_en/in_bit in, out_data/out_valid/settled out
// Integrators run on in_en cycles; the comb section and output stage run
// on the two cycles following each decimation boundary, whatever in_en does.
module dsm_decim3
  import dsm_pkg::*;
#(
  parameter int LOG2R = LOG2R_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  dsm_decim3_if.slave bus
);

  localparam int W     = cic_width(LOG2R);
  localparam int SHIFT = CIC_ORDER * LOG2R - OUT_W;
  localparam int SC_W  = $clog2(SETTLE_CNT + 1);

  generate
    if (LOG2R < 6 || LOG2R > 8) begin : g_bad_log2r
      $error("dsm_decim3: LOG2R must be within 6..8");
    end
  endgenerate

  // The comb result is R^3 times the frame mean, i.e. at most 2^(3*LOG2R).
  // Dropping SHIFT bits maps that onto 0..65536; 65536 itself clips to 65535.
  function automatic logic [OUT_W-1:0] scale_sat(input logic [W-1:0] v);
    logic [W-1:0] s;
    s = v >> SHIFT;
    if (|s[W-1:OUT_W]) begin
      scale_sat = '1;
    end else begin
      scale_sat = s[OUT_W-1:0];
    end
  endfunction

  logic [W-1:0]       in_ext;
  logic [W-1:0]       integ1;
  logic [W-1:0]       integ2;
  logic [W-1:0]       integ3;
  logic [W-1:0]       integ3_next;

  logic [LOG2R-1:0]   cnt_q;
  logic [LOG2R-1:0]   cnt_d;
  logic               frame_end;

  logic [W-1:0]       x_p0_q;
  logic               vld_p0_q;

  logic [W-1:0]       comb1;
  logic [W-1:0]       comb2;
  logic [W-1:0]       comb3;
  logic [W-1:0]       dly1_q;
  logic [W-1:0]       dly2_q;
  logic [W-1:0]       dly3_q;
  logic [SC_W-1:0]    settle_cnt_q;
  logic               settle_done;

  logic [OUT_W-1:0]   data_p1_q;
  logic               vld_p1_q;
  logic               settled_q;

  assign in_ext = W'(bus.in_bit);

  // Each stage adds the previous stage's pre-update value, so chaining the
  // registered outputs gives the textbook integrator cascade.
  cic_integ #(.DATA_W(W)) u_integ1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bus.in_en),
    .din_i (in_ext),
    .acc_o (integ1)
  );

  cic_integ #(.DATA_W(W)) u_integ2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bus.in_en),
    .din_i (integ1),
    .acc_o (integ2)
  );

  cic_integ #(.DATA_W(W)) u_integ3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (bus.in_en),
    .din_i (integ2),
    .acc_o (integ3)
  );

  // The boundary sample must include the update happening on this very
  // in_en cycle, so the last integrator's next value is formed here.
  assign integ3_next = integ3 + integ2;

  assign frame_end = bus.in_en && (cnt_q == {LOG2R{1'b1}});
  assign cnt_d     = bus.in_en ? cnt_q + LOG2R'(1) : cnt_q;

  assign comb1       = x_p0_q - dly1_q;
  assign comb2       = comb1 - dly2_q;
  assign comb3       = comb2 - dly3_q;
  assign settle_done = (settle_cnt_q == SC_W'(SETTLE_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      x_p0_q       <= '0;
      vld_p0_q     <= 1'b0;
      dly1_q       <= '0;
      dly2_q       <= '0;
      dly3_q       <= '0;
      settle_cnt_q <= '0;
      data_p1_q    <= '0;
      vld_p1_q     <= 1'b0;
      settled_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;

      // p0: capture the decimated integrator sample
      vld_p0_q <= frame_end;
      if (frame_end) begin
        x_p0_q <= integ3_next;
      end

      // p1: comb differences, history update, scaling and output register
      vld_p1_q <= vld_p0_q && settle_done;
      if (vld_p0_q) begin
        dly1_q <= x_p0_q;
        dly2_q <= comb1;
        dly3_q <= comb2;
        if (!settle_done) begin
          settle_cnt_q <= settle_cnt_q + SC_W'(1);
        end
      end
      if (vld_p0_q && settle_done) begin
        data_p1_q <= scale_sat(comb3);
        settled_q <= 1'b1;
      end
    end
  end

  assign bus.out_data  = data_p1_q;
  assign bus.out_valid = vld_p1_q;
  assign bus.settled   = settled_q;

endmodule
